// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the fetch PC, applies branch/jump/JR/exception/ERET
// redirects, flags delay slots and fetch address errors, and counts conditional branches.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO     = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI     = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] d_pc,
  input  logic [2:0]  d_npc_op,
  input  logic        cond,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] f_pc,
  output logic        f_bd,
  output logic        f_adel,
  output logic        f_flush,
  output logic [31:0] br_total,
  output logic [31:0] br_taken
);

  localparam logic [2:0] OP_PC4    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_J      = 3'd2;
  localparam logic [2:0] OP_JR     = 3'd3;

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] off);
    branch_target = pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] idx);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    jump_target = {pc4[31:28], idx, 2'b00};
  endfunction

  logic [31:0] pc_next;
  logic        br_count;

  always_comb begin
    pc_next  = f_pc + 32'd4;
    br_count = 1'b0;
    if (exc_req) begin
      pc_next = EXC_HANDLER;
    end else if (stall) begin
      pc_next = f_pc;
    end else if (eret) begin
      pc_next = epc;
    end else begin
      case (d_npc_op)
        OP_BRANCH: begin
          br_count = 1'b1;
          if (cond) pc_next = branch_target(d_pc, d_imm26[15:0]);
        end
        OP_J:    pc_next = jump_target(d_pc, d_imm26);
        OP_JR:   pc_next = d_rs;
        default: pc_next = f_pc + 32'd4;
      endcase
    end
  end

  // F-stage register boundary: fetch PC and branch statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc     <= RESET_PC;
      br_total <= 32'd0;
      br_taken <= 32'd0;
    end else begin
      f_pc <= pc_next;
      if (br_count) begin
        br_total <= br_total + 32'd1;
        if (cond) br_taken <= br_taken + 32'd1;
      end
    end
  end

  // ERET suppresses the delay-slot flag because the instruction after it is nullified.
  assign f_bd    = ((d_npc_op == OP_BRANCH) || (d_npc_op == OP_J) || (d_npc_op == OP_JR)) && !eret;
  assign f_flush = eret && !stall && !exc_req;
  assign f_adel  = (f_pc[1:0] != 2'b00) || (f_pc < TEXT_LO) || (f_pc > TEXT_HI);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] d_pc = '0;
  logic [2:0]  d_npc_op = '0;
  logic        cond = 1'b0;
  logic [25:0] d_imm26 = '0;
  logic [31:0] d_rs = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] f_pc;
  logic        f_bd, f_adel, f_flush;
  logic [31:0] br_total, br_taken;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] pc;
    logic        bd;
    logic        adel;
    logic        flush;
    logic [31:0] tot;
    logic [31:0] tak;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_id = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .d_pc(d_pc), .d_npc_op(d_npc_op),
    .cond(cond), .d_imm26(d_imm26), .d_rs(d_rs), .exc_req(exc_req), .eret(eret),
    .epc(epc), .f_pc(f_pc), .f_bd(f_bd), .f_adel(f_adel), .f_flush(f_flush),
    .br_total(br_total), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input exp_t e);
    checks++;
    if (f_pc !== e.pc || f_bd !== e.bd || f_adel !== e.adel || f_flush !== e.flush ||
        br_total !== e.tot || br_taken !== e.tak) begin
      errors++;
      $display("FAIL %s: got pc=%h bd=%b adel=%b flush=%b tot=%0d tak=%0d, want pc=%h bd=%b adel=%b flush=%b tot=%0d tak=%0d",
               name, f_pc, f_bd, f_adel, f_flush, br_total, br_taken,
               e.pc, e.bd, e.adel, e.flush, e.tot, e.tak);
    end
  endtask

  // Monitor: one expectation per cycle, checked at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        compare($sformatf("cyc%0d", e.id), e);
      end
    end
  end

  // Drive the inputs for the coming edge and queue what the outputs must show at this
  // cycle's negedge: f_pc/counters from the edge just passed, flags from these inputs.
  task automatic cyc(input logic st, input logic [2:0] op, input logic cd, input logic [31:0] dpc,
                     input logic [25:0] imm, input logic [31:0] rs, input logic ex, input logic er,
                     input logic [31:0] ep, input logic [31:0] e_pc, input logic e_bd,
                     input logic e_adel, input logic e_flush, input logic [31:0] e_tot,
                     input logic [31:0] e_tak);
    exp_t e;
    @(posedge clk);
    #1;
    stall = st; d_npc_op = op; cond = cd; d_pc = dpc; d_imm26 = imm; d_rs = rs;
    exc_req = ex; eret = er; epc = ep;
    cyc_id++;
    e.id = 8'(cyc_id); e.pc = e_pc; e.bd = e_bd; e.adel = e_adel; e.flush = e_flush;
    e.tot = e_tot; e.tak = e_tak;
    q.push_back(e);
  endtask

  initial begin
    exp_t r;
    int n;
    #1 reset = 1'b1;
    #2;
    r = '{id: 8'd0, pc: 32'h3000, bd: 1'b0, adel: 1'b0, flush: 1'b0, tot: 32'd0, tak: 32'd0};
    compare("reset_state", r);
    #9 reset = 1'b0;

    // idle sequential fetch
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h300c, 0, 0, 0, 0, 0);
    // taken backward branch
    cyc(0, 3'd1, 1, 32'h3010, 26'h000fffe, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 0, 0);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h300c, 0, 0, 0, 1, 1);
    // untaken branch still marks the delay slot
    cyc(0, 3'd1, 0, 32'h300c, 26'h000fffe, 0, 0, 0, 0, 32'h3010, 1, 0, 0, 1, 1);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3014, 0, 0, 0, 2, 1);
    // branch held by stall for three edges, counted once
    cyc(1, 3'd1, 1, 32'h3014, 26'h0000004, 0, 0, 0, 0, 32'h3018, 1, 0, 0, 2, 1);
    cyc(1, 3'd1, 1, 32'h3014, 26'h0000004, 0, 0, 0, 0, 32'h3018, 1, 0, 0, 2, 1);
    cyc(1, 3'd1, 1, 32'h3014, 26'h0000004, 0, 0, 0, 0, 32'h3018, 1, 0, 0, 2, 1);
    cyc(0, 3'd1, 1, 32'h3014, 26'h0000004, 0, 0, 0, 0, 32'h3018, 1, 0, 0, 2, 1);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3028, 0, 0, 0, 3, 2);
    // JR targets: misaligned, above text, legal
    cyc(0, 3'd3, 0, 0, 0, 32'h3002, 0, 0, 0, 32'h302c, 1, 0, 0, 3, 2);
    cyc(0, 3'd3, 0, 0, 0, 32'h7000, 0, 0, 0, 32'h3002, 1, 1, 0, 3, 2);
    cyc(0, 3'd3, 0, 0, 0, 32'h4000, 0, 0, 0, 32'h7000, 1, 1, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h4000, 0, 0, 0, 3, 2);
    // exception beats stall and a taken branch
    cyc(1, 3'd1, 1, 32'h4000, 0, 0, 1, 0, 0, 32'h4004, 1, 0, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3020, 32'h4180, 0, 0, 1, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3020, 0, 0, 0, 3, 2);
    // eret beats a branch op
    cyc(0, 3'd1, 1, 32'h3020, 26'h0000010, 0, 0, 1, 32'h3040, 32'h3024, 0, 0, 1, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3040, 0, 0, 0, 3, 2);
    // J uses the upper nibble of d_pc+4
    cyc(0, 3'd2, 0, 32'h3ffc, 26'h0000c00, 0, 0, 0, 0, 32'h3044, 1, 0, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 3, 2);
    // exception with eret: no flush, exception target wins
    cyc(0, 3'd0, 0, 0, 0, 0, 1, 1, 32'h5000, 32'h3004, 0, 0, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h4180, 0, 0, 0, 3, 2);
    // PC wrap past 0xffff_fffc
    cyc(0, 3'd3, 0, 0, 0, 32'hffff_fffc, 0, 0, 0, 32'h4184, 1, 0, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'hffff_fffc, 0, 1, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 0, 3, 2);
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 0, 1, 0, 3, 2);

    // asynchronous reset pulse in the middle of a cycle
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    r = '{id: 8'd0, pc: 32'h3000, bd: 1'b0, adel: 1'b0, flush: 1'b0, tot: 32'd0, tak: 32'd0};
    compare("async_reset", r);
    #2 reset = 1'b0;
    cyc(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0, 0, 0);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
